// File: rtl/motor_rate_sequencer_pkg.sv
// Shared definitions for the motor rate sequencer: default rate width and
// sequencer state encodings seen on state_out.
package motor_rate_sequencer_pkg;

  localparam int MOTOR_RATE_BIT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEQ_DISARMED = 2'd0,
    SEQ_ARMING   = 2'd1,
    SEQ_ARMED    = 2'd2,
    SEQ_FAILSAFE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/motor_rate_sequencer_slew_limiter.sv
// One motor's next rate: saturating step of at most MAX_STEP toward the
// target, or toward zero when ramping down. Holds when step_en is low.
module slew_limiter
  import motor_rate_sequencer_pkg::*;
#(
  parameter int RATE_W   = MOTOR_RATE_BIT_WIDTH,
  parameter int MAX_STEP = 8
) (
  input  logic [RATE_W-1:0] current,
  input  logic [RATE_W-1:0] target,
  input  logic              step_en,
  input  logic              ramp_down,
  output logic [RATE_W-1:0] next_rate
);

  localparam logic [RATE_W:0] STEP = (RATE_W+1)'(MAX_STEP);

  logic              up;
  logic [RATE_W-1:0] diff;

  always_comb begin
    up        = target > current;
    diff      = up ? (target - current) : (current - target);
    next_rate = current;
    if (step_en) begin
      // Step only when strictly further than STEP away, so no over/undershoot or wrap.
      if (ramp_down)
        next_rate = ({1'b0, current} > STEP) ? current - STEP[RATE_W-1:0] : '0;
      else if ({1'b0, diff} > STEP)
        next_rate = up ? current + STEP[RATE_W-1:0] : current - STEP[RATE_W-1:0];
      else
        next_rate = target;
    end
  end

endmodule

// File: rtl/motor_rate_sequencer.sv
// ESC arming/disarming, per-period slew limiting and command watchdog feeding
// the four pwm_generator rate inputs.
module motor_rate_sequencer
  import motor_rate_sequencer_pkg::*;
#(
  parameter int RATE_W              = MOTOR_RATE_BIT_WIDTH,
  parameter int PERIOD_US           = 20000,
  parameter int ARM_PERIODS         = 50,
  parameter int MAX_STEP            = 8,
  parameter int ARM_MAX_THROTTLE    = 16,
  parameter int CMD_TIMEOUT_PERIODS = 10
) (
  input  logic              us_clk,
  input  logic              reset,
  input  logic              arm_req,
  input  logic              disarm_req,
  input  logic              cmd_valid,
  input  logic [RATE_W-1:0] cmd_m1,
  input  logic [RATE_W-1:0] cmd_m2,
  input  logic [RATE_W-1:0] cmd_m3,
  input  logic [RATE_W-1:0] cmd_m4,
  output logic [RATE_W-1:0] motor_1_rate,
  output logic [RATE_W-1:0] motor_2_rate,
  output logic [RATE_W-1:0] motor_3_rate,
  output logic [RATE_W-1:0] motor_4_rate,
  output logic              armed,
  output logic              failsafe,
  output logic [1:0]        state_out
);

  localparam int CNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int ARM_W = $clog2(ARM_PERIODS + 1);
  localparam int WD_W  = $clog2(CMD_TIMEOUT_PERIODS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_US - 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_PERIODS);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(CMD_TIMEOUT_PERIODS);
  localparam logic [RATE_W:0]  ARM_MAX  = (RATE_W+1)'(ARM_MAX_THROTTLE);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              armed_q, armed_d;
  logic              failsafe_q, failsafe_d;
  logic [RATE_W-1:0] rate_q [4];
  logic [RATE_W-1:0] rate_d [4];
  logic [RATE_W-1:0] rate_next [4];
  logic [RATE_W-1:0] tgt_q [4];
  logic [RATE_W-1:0] tgt_d [4];
  logic [RATE_W-1:0] cmd [4];
  logic              tick, step_en, ramp_down, targets_low, all_zero;

  assign cmd[0] = cmd_m1;
  assign cmd[1] = cmd_m2;
  assign cmd[2] = cmd_m3;
  assign cmd[3] = cmd_m4;

  assign tick      = (cnt_q == CNT_LAST);
  assign ramp_down = (state_q == SEQ_FAILSAFE);
  assign step_en   = tick && ((state_q == SEQ_ARMED) || ramp_down);

  for (genvar g = 0; g < 4; g++) begin : g_slew
    slew_limiter #(
      .RATE_W  (RATE_W),
      .MAX_STEP(MAX_STEP)
    ) u_slew (
      .current  (rate_q[g]),
      .target   (tgt_q[g]),
      .step_en  (step_en),
      .ramp_down(ramp_down),
      .next_rate(rate_next[g])
    );
  end

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    wd_d        = wd_q;
    failsafe_d  = failsafe_q;
    targets_low = 1'b1;
    all_zero    = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tgt_d[i]  = cmd_valid ? cmd[i] : tgt_q[i];
      rate_d[i] = rate_next[i];
      if ({1'b0, tgt_q[i]} > ARM_MAX) targets_low = 1'b0;
      if (rate_next[i] != '0) all_zero = 1'b0;
    end

    if (cmd_valid)
      wd_d = '0;
    else if (tick && (state_q == SEQ_ARMED) && (wd_q != WD_LIMIT))
      wd_d = wd_q + 1'b1;

    case (state_q)
      SEQ_DISARMED: begin
        if (arm_req && targets_low) begin
          state_d   = SEQ_ARMING;
          arm_cnt_d = '0;
        end
      end
      SEQ_ARMING: begin
        if (tick) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
          if (arm_cnt_d == ARM_DONE) begin
            state_d = SEQ_ARMED;
            wd_d    = '0;
          end
        end
      end
      SEQ_ARMED: begin
        if (wd_q == WD_LIMIT) begin
          state_d    = SEQ_FAILSAFE;
          failsafe_d = 1'b1;
        end
      end
      SEQ_FAILSAFE: begin
        if (tick && all_zero) state_d = SEQ_DISARMED;
      end
      default: state_d = SEQ_DISARMED;
    endcase

    // Disarm overrides everything above, including a same-cycle arm_req.
    if (disarm_req) begin
      state_d    = SEQ_DISARMED;
      failsafe_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) rate_d[i] = '0;
    end

    armed_d = (state_d == SEQ_ARMED);
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEQ_DISARMED;
      cnt_q      <= '0;
      arm_cnt_q  <= '0;
      wd_q       <= '0;
      armed_q    <= 1'b0;
      failsafe_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        rate_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      wd_q       <= wd_d;
      armed_q    <= armed_d;
      failsafe_q <= failsafe_d;
      for (int unsigned i = 0; i < 4; i++) begin
        rate_q[i] <= rate_d[i];
        tgt_q[i]  <= tgt_d[i];
      end
    end
  end

  assign motor_1_rate = rate_q[0];
  assign motor_2_rate = rate_q[1];
  assign motor_3_rate = rate_q[2];
  assign motor_4_rate = rate_q[3];
  assign armed        = armed_q;
  assign failsafe     = failsafe_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_motor_rate_sequencer.sv
// Directed bench for motor_rate_sequencer: a per-cycle behavioural model is
// compared every cycle, plus hand-computed checkpoints along each scenario.
module tb_motor_rate_sequencer;

  localparam int P    = 10;
  localparam int ARMP = 3;
  localparam int STEP = 16;
  localparam int TMO  = 4;
  localparam int AMAX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm_req = 1'b0, disarm_req = 1'b0, cmd_valid = 1'b0;
  logic [7:0] cmd_v = '0;
  logic [7:0] r1, r2, r3, r4;
  logic       armed, failsafe;
  logic [1:0] state_out;

  int total = 0;
  int bad   = 0;

  // Model state: 0 disarmed, 1 arming, 2 armed, 3 failsafe
  int m_state = 0, m_cnt = 0, m_wd = 0, m_arm = 0, m_fs = 0;
  int m_rate[4] = '{0, 0, 0, 0};
  int m_tgt[4]  = '{0, 0, 0, 0};
  bit m_ticked  = 1'b0;

  always #5 clk = ~clk;

  motor_rate_sequencer #(
    .RATE_W(8), .PERIOD_US(P), .ARM_PERIODS(ARMP), .MAX_STEP(STEP),
    .ARM_MAX_THROTTLE(AMAX), .CMD_TIMEOUT_PERIODS(TMO)
  ) dut (
    .us_clk(clk), .reset(rst), .arm_req(arm_req), .disarm_req(disarm_req),
    .cmd_valid(cmd_valid), .cmd_m1(cmd_v), .cmd_m2(cmd_v), .cmd_m3(cmd_v), .cmd_m4(cmd_v),
    .motor_1_rate(r1), .motor_2_rate(r2), .motor_3_rate(r3), .motor_4_rate(r4),
    .armed(armed), .failsafe(failsafe), .state_out(state_out)
  );

  function automatic int dut_rate(input int i);
    case (i)
      0: return int'(r1);
      1: return int'(r2);
      2: return int'(r3);
      default: return int'(r4);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rates(input string name, input int v);
    for (int i = 0; i < 4; i++) check($sformatf("%s_m%0d", name, i + 1), dut_rate(i), v);
  endtask

  task automatic next_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * P && !seen; i++) begin
      @(negedge clk);
      seen = m_ticked;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tick_wait: got no tick expected a tick within %0d cycles", 2 * P);
    end
  endtask

  task automatic pulse(input bit a, input bit d);
    arm_req = a;
    disarm_req = d;
    @(negedge clk);
    arm_req = 1'b0;
    disarm_req = 1'b0;
  endtask

  // Behavioural model, updated on every active edge from the inputs seen there
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; m_cnt = 0; m_wd = 0; m_arm = 0; m_fs = 0; m_ticked = 1'b0;
      for (int i = 0; i < 4; i++) begin m_rate[i] = 0; m_tgt[i] = 0; end
    end else begin
      bit tk, low, allz;
      int old_wd, old_state, d;
      tk = (m_cnt == P - 1);
      m_ticked = tk;
      m_cnt = tk ? 0 : m_cnt + 1;
      old_wd = m_wd;
      old_state = m_state;
      if (disarm_req) begin
        m_state = 0; m_fs = 0;
        for (int i = 0; i < 4; i++) m_rate[i] = 0;
      end else begin
        case (m_state)
          0: begin
            low = 1'b1;
            for (int i = 0; i < 4; i++) if (m_tgt[i] > AMAX) low = 1'b0;
            if (arm_req && low) begin m_state = 1; m_arm = 0; end
          end
          1: if (tk) begin
            m_arm++;
            if (m_arm == ARMP) begin m_state = 2; m_wd = 0; end
          end
          2: begin
            if (tk)
              for (int i = 0; i < 4; i++) begin
                d = m_tgt[i] - m_rate[i];
                if (d > STEP) m_rate[i] += STEP;
                else if (d < -STEP) m_rate[i] -= STEP;
                else m_rate[i] = m_tgt[i];
              end
            if (old_wd == TMO) begin m_state = 3; m_fs = 1; end
          end
          default: if (tk) begin
            allz = 1'b1;
            for (int i = 0; i < 4; i++) begin
              m_rate[i] = (m_rate[i] > STEP) ? m_rate[i] - STEP : 0;
              if (m_rate[i] != 0) allz = 1'b0;
            end
            if (allz) m_state = 0;
          end
        endcase
      end
      if (cmd_valid) begin
        m_wd = 0;
        for (int i = 0; i < 4; i++) m_tgt[i] = int'(cmd_v);
      end else if (tk && old_state == 2 && m_wd < TMO) begin
        m_wd++;
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) check($sformatf("cyc_rate%0d", i + 1), dut_rate(i), m_rate[i]);
      check("cyc_state", int'(state_out), m_state);
      check("cyc_armed", int'(armed), (m_state == 2) ? 1 : 0);
      check("cyc_failsafe", int'(failsafe), m_fs);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_dn[7] = '{84, 68, 52, 36, 20, 4, 0};
    int exp_up[7] = '{16, 32, 48, 64, 80, 96, 100};

    repeat (3) @(negedge clk);
    check_rates("rst", 0);
    check("rst_state", int'(state_out), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_failsafe", int'(failsafe), 0);
    rst = 1'b0;

    // 1: arm with zero targets, three ticks of forced zero
    pulse(1'b1, 1'b0);
    check("t1_arming", int'(state_out), 1);
    for (int k = 0; k < ARMP; k++) begin
      next_tick();
      if (k < ARMP - 1) begin
        check("t1_hold_state", int'(state_out), 1);
        check_rates("t1_hold", 0);
      end
    end
    check("t1_armed_state", int'(state_out), 2);
    check("t1_armed", int'(armed), 1);

    // 2: ramp up to 100
    cmd_valid = 1'b1;
    cmd_v = 8'd100;
    for (int k = 0; k < 7; k++) begin
      next_tick();
      check_rates($sformatf("t2_up%0d", k), exp_up[k]);
    end
    next_tick();
    check_rates("t2_hold", 100);

    // 3: ramp down to 40 without undershoot, then up to 255 without wrap
    cmd_v = 8'd40;
    next_tick(); check_rates("t3_84", 84);
    next_tick(); check_rates("t3_68", 68);
    next_tick(); check_rates("t3_52", 52);
    next_tick(); check_rates("t3_40", 40);
    cmd_v = 8'd250;
    for (int k = 0; k < 14; k++) next_tick();
    check_rates("t3_250", 250);
    cmd_v = 8'd255;
    next_tick(); check_rates("t3_255", 255);
    next_tick(); check_rates("t3_255_hold", 255);

    // 4: command loss -> failsafe ramp-down -> disarmed with failsafe sticky
    cmd_v = 8'd100;
    for (int k = 0; k < 10; k++) next_tick();
    check_rates("t4_100", 100);
    cmd_valid = 1'b0;
    for (int k = 0; k < TMO; k++) next_tick();
    check("t4_still_armed", int'(state_out), 2);
    @(negedge clk);
    check("t4_fs_state", int'(state_out), 3);
    check("t4_fs_flag", int'(failsafe), 1);
    for (int k = 0; k < 7; k++) begin
      next_tick();
      check_rates($sformatf("t4_dn%0d", k), exp_dn[k]);
    end
    check("t4_disarmed", int'(state_out), 0);
    check("t4_fs_sticky", int'(failsafe), 1);

    // 5: arm refused with high target; disarm beats arm in the same cycle
    cmd_valid = 1'b1;
    cmd_v = 8'd200;
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("t5_refused", int'(state_out), 0);
    cmd_v = 8'd0;
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("t5_arming", int'(state_out), 1);
    for (int k = 0; k < ARMP; k++) next_tick();
    check("t5_armed", int'(state_out), 2);
    check("t5_fs_kept", int'(failsafe), 1);
    cmd_v = 8'd80;
    for (int k = 0; k < 5; k++) next_tick();
    check_rates("t5_80", 80);
    cmd_v = 8'd0;
    @(negedge clk);
    pulse(1'b1, 1'b1);
    check_rates("t5_disarm", 0);
    check("t5_dis_state", int'(state_out), 0);
    check("t5_dis_fs", int'(failsafe), 0);
    check("t5_dis_armed", int'(armed), 0);
    @(negedge clk);
    check("t5_arm_dropped", int'(state_out), 0);

    // 6: asynchronous reset mid-period, then tick phase restarts
    pulse(1'b1, 1'b0);
    for (int k = 0; k < ARMP; k++) next_tick();
    cmd_v = 8'd64;
    for (int k = 0; k < 4; k++) next_tick();
    check_rates("t6_64", 64);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check_rates("t6_async", 0);
    check("t6_async_armed", int'(armed), 0);
    check("t6_async_fs", int'(failsafe), 0);
    check("t6_async_state", int'(state_out), 0);
    @(negedge clk);
    rst = 1'b0;
    arm_req = 1'b1;
    @(negedge clk);
    arm_req = 1'b0;
    repeat (3 * P - 2) @(negedge clk);
    check("t6_before_3rd_tick", int'(state_out), 1);
    @(negedge clk);
    check("t6_after_3rd_tick", int'(state_out), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
